// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman front-end: symbol alphabet, counter
// width, run-length limit and the frequency-count sequencer state encoding.
// Reused by the counter bank, the tree builder and freq_count_ctrl.
package huff_pkg;

  localparam int NSYM    = 10;   // symbols / counters 0..NSYM-1
  localparam int CNT_W   = 8;    // counter and frequency width
  localparam int MAX_LEN = 255;  // symbols per run, <= 2**CNT_W-1
  localparam int SYM_W   = 4;    // symbol / counter index width
  localparam int LEN_W   = 8;    // run-length register width

  localparam logic [SYM_W-1:0] TERM_MIN = 4'hA;  // A-F end the stream

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_SCAN,
    ST_DONE
  } state_t;

  // A-F never reach the counter bank; they only close the counting phase.
  function automatic logic is_term(input logic [SYM_W-1:0] sym);
    return sym >= TERM_MIN;
  endfunction

endpackage

// File: rtl/freq_count_ctrl_if.sv
// Symbol/frequency stream towards the tree builder.
//   Sym_valid  master->slave  Sym_out/Sym_freq carry a pair
//   Sym_ready  slave->master  pair accepted when high with Sym_valid
//   Sym_out    master->slave  symbol index
//   Sym_freq   master->slave  frequency of Sym_out
interface freq_count_ctrl_if import huff_pkg::*; ();

  logic             Sym_valid;
  logic             Sym_ready;
  logic [SYM_W-1:0] Sym_out;
  logic [CNT_W-1:0] Sym_freq;

  modport master (output Sym_valid, Sym_out, Sym_freq, input Sym_ready);
  modport slave  (input Sym_valid, Sym_out, Sym_freq, output Sym_ready);

endinterface

// File: rtl/freq_count_ctrl.sv
// Sequencer for the symbol-frequency counter bank. A run clears the bank,
// counts digits 0-9 from the input stream until a terminator (A-F) or the
// length limit, then scans the bank in ascending order and emits every
// non-zero (symbol, frequency) pair over a valid/ready stream.
// Ports:
//   Clk_in, nRst       clock (rising edge), async active-low reset
//   Start              run request, honoured only in IDLE
//   Data_in/Data_valid input symbol stream
//   Cnt_clr/Cnt_en     bank clear / increment of counter Cnt_sel
//   Cnt_sel            counter index for increment (COUNT) and read (SCAN)
//   Cnt_rd_data        asynchronous read of counter Cnt_sel
//   sym                pair stream to the tree builder (master side)
//   Len/Nz_cnt         symbols accepted / pairs emitted in current or last run
//   Busy/Done          not idle / one-cycle end-of-run pulse
module freq_count_ctrl
  import huff_pkg::*;
(
  input  logic                     Clk_in,
  input  logic                     nRst,
  input  logic                     Start,
  input  logic [SYM_W-1:0]         Data_in,
  input  logic                     Data_valid,
  output logic                     Cnt_clr,
  output logic                     Cnt_en,
  output logic [SYM_W-1:0]         Cnt_sel,
  input  logic [CNT_W-1:0]         Cnt_rd_data,
  freq_count_ctrl_if.master        sym,
  output logic [LEN_W-1:0]         Len,
  output logic [SYM_W-1:0]         Nz_cnt,
  output logic                     Busy,
  output logic                     Done
);

  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 1);
  localparam logic [SYM_W-1:0] IDX_LAST = SYM_W'(NSYM - 1);

  state_t           state, state_nxt;
  logic [SYM_W-1:0] idx, idx_nxt;
  logic [LEN_W-1:0] len_nxt;
  logic [SYM_W-1:0] nz_nxt;
  logic             scan_hit;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      Len    <= '0;
      Nz_cnt <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      Len    <= len_nxt;
      Nz_cnt <= nz_nxt;
    end
  end

  // A zero counter is skipped without presenting a pair.
  assign scan_hit = |Cnt_rd_data;

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    len_nxt       = Len;
    nz_nxt        = Nz_cnt;
    Cnt_clr       = 1'b0;
    Cnt_en        = 1'b0;
    Cnt_sel       = '0;
    sym.Sym_valid = 1'b0;
    sym.Sym_out   = '0;
    sym.Sym_freq  = '0;

    unique case (state)
      ST_IDLE: begin
        if (Start) state_nxt = ST_CLEAR;
      end

      ST_CLEAR: begin
        Cnt_clr   = 1'b1;
        len_nxt   = '0;
        nz_nxt    = '0;
        idx_nxt   = '0;
        state_nxt = ST_COUNT;
      end

      ST_COUNT: begin
        if (Data_valid) begin
          if (is_term(Data_in)) begin
            state_nxt = ST_SCAN;
          end else begin
            Cnt_en  = 1'b1;
            Cnt_sel = Data_in;
            len_nxt = Len + 1'b1;
            // Last allowed symbol: counters can no longer overflow after this.
            if (Len == LEN_LAST) state_nxt = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        Cnt_sel       = idx;
        sym.Sym_out   = idx;
        sym.Sym_freq  = Cnt_rd_data;
        sym.Sym_valid = scan_hit;
        // Advance on an empty slot or on a completed handshake; a pending
        // pair keeps idx (and therefore Sym_out/Sym_freq) frozen.
        if (!scan_hit || sym.Sym_ready) begin
          if (scan_hit) nz_nxt = Nz_cnt + 1'b1;
          if (idx == IDX_LAST) begin
            idx_nxt   = '0;
            state_nxt = ST_DONE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign Busy = (state != ST_IDLE);
  assign Done = (state == ST_DONE);

endmodule

// File: tb/tb_freq_count_ctrl.sv
module tb_freq_count_ctrl;
  import huff_pkg::*;

  logic             Clk_in = 1'b0;
  logic             nRst = 1'b0;
  logic             Start = 1'b0;
  logic [SYM_W-1:0] Data_in = '0;
  logic             Data_valid = 1'b0;
  logic             Cnt_clr, Cnt_en;
  logic [SYM_W-1:0] Cnt_sel;
  logic [CNT_W-1:0] Cnt_rd_data;
  logic [LEN_W-1:0] Len;
  logic [SYM_W-1:0] Nz_cnt;
  logic             Busy, Done;

  freq_count_ctrl_if sym_bus ();

  freq_count_ctrl dut (
    .Clk_in      (Clk_in),
    .nRst        (nRst),
    .Start       (Start),
    .Data_in     (Data_in),
    .Data_valid  (Data_valid),
    .Cnt_clr     (Cnt_clr),
    .Cnt_en      (Cnt_en),
    .Cnt_sel     (Cnt_sel),
    .Cnt_rd_data (Cnt_rd_data),
    .sym         (sym_bus),
    .Len         (Len),
    .Nz_cnt      (Nz_cnt),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 Clk_in = ~Clk_in;

  // External counter bank: not touched by nRst, only by Cnt_clr/Cnt_en.
  logic [CNT_W-1:0] bank [NSYM];
  always @(posedge Clk_in) begin
    if (Cnt_clr) begin
      for (int i = 0; i < NSYM; i++) bank[i] <= '0;
    end else if (Cnt_en && Cnt_sel < SYM_W'(NSYM)) begin
      bank[Cnt_sel] <= bank[Cnt_sel] + 1'b1;
    end
  end
  assign Cnt_rd_data = (Cnt_sel < SYM_W'(NSYM)) ? bank[Cnt_sel] : '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int          cyc = 0, en_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int          clr_cyc = 0, done_cyc = 0, wait_cnt = 0;
  int          got_sym[$], got_freq[$];
  bit          prev_stall = 0;
  logic [31:0] prev_out = 0, prev_freq = 0;
  int          ready_mode = 0;

  initial begin
    forever begin
      @(negedge Clk_in);
      cyc++;
      if (!nRst) begin
        prev_stall = 0;
        wait_cnt   = 0;
      end else begin
        if (Cnt_en) en_cnt++;
        if (Cnt_clr) begin clr_cnt++; clr_cyc = cyc; end
        if (Done) begin done_cnt++; done_cyc = cyc; end
        if (prev_stall) begin
          check("hold_valid", 32'(sym_bus.Sym_valid), 1);
          check("hold_sym", 32'(sym_bus.Sym_out), prev_out);
          check("hold_freq", 32'(sym_bus.Sym_freq), prev_freq);
        end
        if (sym_bus.Sym_valid && sym_bus.Sym_ready) begin
          got_sym.push_back(int'(sym_bus.Sym_out));
          got_freq.push_back(int'(sym_bus.Sym_freq));
          wait_cnt = 0;
        end else if (sym_bus.Sym_valid) begin
          wait_cnt++;
        end
        prev_stall = sym_bus.Sym_valid && !sym_bus.Sym_ready;
        prev_out   = 32'(sym_bus.Sym_out);
        prev_freq  = 32'(sym_bus.Sym_freq);
      end
    end
  end

  // Downstream ready: 0 always high, 1 random, 2 five low cycles per pair.
  initial begin
    sym_bus.Sym_ready = 1'b0;
    forever begin
      @(posedge Clk_in);
      #1;
      case (ready_mode)
        0:       sym_bus.Sym_ready = 1'b1;
        1:       sym_bus.Sym_ready = 1'($urandom_range(0, 1));
        default: sym_bus.Sym_ready = (wait_cnt >= 5);
      endcase
    end
  end

  // ---------------- one run against the reference model ----------------
  // items: -1 = idle cycle, 0..15 = symbol presented with Data_valid.
  task automatic run_case(input string name, input int items[$], input int mode,
                          input bit inject, input bit check_lat);
    int cnt[NSYM];
    int acc = 0;
    int exp_sym[$], exp_freq[$];
    bit scan_inj = 0;
    int n;

    // Reference: count accepted digits up to terminator or length limit.
    foreach (cnt[s]) cnt[s] = 0;
    foreach (items[i]) begin
      if (items[i] < 0) continue;
      if (items[i] >= NSYM) break;
      cnt[items[i]]++;
      acc++;
      if (acc == MAX_LEN) break;
    end
    for (int s = 0; s < NSYM; s++)
      if (cnt[s] != 0) begin exp_sym.push_back(s); exp_freq.push_back(cnt[s]); end

    en_cnt = 0; clr_cnt = 0; done_cnt = 0;
    got_sym.delete(); got_freq.delete();
    ready_mode = mode;

    @(posedge Clk_in); #1 Start = 1'b1;
    @(posedge Clk_in); #1 Start = 1'b0;   // DUT now in CLEAR
    @(posedge Clk_in); #1;                // DUT now in COUNT
    foreach (items[i]) begin
      Start = inject && (i == 2);
      if (items[i] < 0) begin
        Data_valid = 1'b0;
      end else begin
        Data_valid = 1'b1;
        Data_in    = SYM_W'(items[i]);
      end
      @(posedge Clk_in); #1;
    end
    Start = 1'b0;
    Data_valid = 1'b0;

    for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
      if (inject && !scan_inj && sym_bus.Sym_valid) begin
        Start = 1'b1;
        scan_inj = 1;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk_in); #1;
    end
    Start = 1'b0;
    check({name, "_done_seen"}, 32'(done_cnt > 0), 1);
    repeat (3) @(posedge Clk_in);
    #1;

    check({name, "_done_pulses"}, 32'(done_cnt), 1);
    check({name, "_clr_pulses"}, 32'(clr_cnt), 1);
    check({name, "_en_pulses"}, 32'(en_cnt), 32'(acc));
    check({name, "_len"}, 32'(Len), 32'(acc));
    check({name, "_nz_cnt"}, 32'(Nz_cnt), 32'(exp_sym.size()));
    check({name, "_pairs"}, 32'(got_sym.size()), 32'(exp_sym.size()));
    n = (got_sym.size() < exp_sym.size()) ? got_sym.size() : exp_sym.size();
    for (int k = 0; k < n; k++) begin
      check({name, "_pair_sym"}, 32'(got_sym[k]), 32'(exp_sym[k]));
      check({name, "_pair_freq"}, 32'(got_freq[k]), 32'(exp_freq[k]));
    end
    check({name, "_busy_end"}, 32'(Busy), 0);
    if (check_lat) check({name, "_clr_to_done"}, 32'(done_cyc - clr_cyc), 12);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int q[$];

    #2;
    check("rst_busy", 32'(Busy), 0);
    check("rst_done", 32'(Done), 0);
    check("rst_len", 32'(Len), 0);
    check("rst_nz", 32'(Nz_cnt), 0);
    check("rst_clr", 32'(Cnt_clr), 0);
    check("rst_en", 32'(Cnt_en), 0);
    check("rst_valid", 32'(sym_bus.Sym_valid), 0);
    repeat (2) @(posedge Clk_in);
    #1 nRst = 1'b1;
    repeat (2) @(posedge Clk_in);
    #1 check("idle_no_start_busy", 32'(Busy), 0);

    run_case("basic", '{3, 3, 7, 0, 'hA}, 0, 0, 0);
    // Results hold in IDLE until the next run is accepted.
    repeat (4) @(posedge Clk_in);
    #1 check("idle_len_hold", 32'(Len), 4);
    check("idle_nz_hold", 32'(Nz_cnt), 3);

    run_case("stall", '{3, 3, 7, 0, 'hA}, 2, 0, 0);
    run_case("term_first", '{'hF}, 0, 0, 1);

    q.delete();
    repeat (300) q.push_back(5);
    run_case("max_len", q, 0, 0, 0);

    run_case("restart_ignored", '{1, 2, -1, 2, 'hC, 4}, 1, 1, 0);

    // Reset mid-COUNT after two counted symbols.
    ready_mode = 0;
    @(posedge Clk_in); #1 Start = 1'b1;
    @(posedge Clk_in); #1 Start = 1'b0;
    @(posedge Clk_in); #1 Data_valid = 1'b1; Data_in = 4'd3;
    @(posedge Clk_in); #1 Data_in = 4'd3;
    @(posedge Clk_in); #1 Data_valid = 1'b0;
    check("pre_rst_len", 32'(Len), 2);
    nRst = 1'b0;
    #2;
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_len", 32'(Len), 0);
    check("mid_rst_nz", 32'(Nz_cnt), 0);
    check("mid_rst_done", 32'(Done), 0);
    @(posedge Clk_in); #1 nRst = 1'b1;
    run_case("after_rst", '{9, 'hB}, 0, 0, 0);

    // Randomized runs: digits with idle gaps, a terminator, then ignored junk.
    for (int r = 0; r < 8; r++) begin
      int len;
      q.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) q.push_back(-1);
        else q.push_back($urandom_range(0, NSYM - 1));
      end
      q.push_back($urandom_range(10, 15));
      repeat ($urandom_range(0, 3)) q.push_back($urandom_range(0, 15));
      run_case($sformatf("rand%0d", r), q, $urandom_range(0, 2), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
